// File: rtl/dm_io_sequencer_pkg.sv
// Shared definitions for the DM I/O sequencer and the downstream DM selector:
// selector status encodings, sequencer FSM states and default widths.
package dm_io_sequencer_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 16;

  // Selector mode, decoded by the DM selector to pick who owns the memory
  localparam logic [1:0] ST_LOAD = 2'b00;
  localparam logic [1:0] ST_CORE = 2'b01;
  localparam logic [1:0] ST_READ = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LOAD    = 3'd1,
    S_RUN     = 3'd2,
    S_RD_ADDR = 3'd3,
    S_RD_WAIT = 3'd4,
    S_FIN     = 3'd5
  } seq_state_t;

endpackage

// File: rtl/dm_io_sequencer_addr.sv
// dm_addr_counter: word counter producing base+count (modulo 2^ADDR_W)
// and a flag marking the final word of a phase.
module dm_addr_counter #(
  parameter int ADDR_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_clear,
  input  logic              i_inc,
  input  logic [ADDR_W-1:0] i_base,
  input  logic [ADDR_W-1:0] i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);

  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] w_len_m1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc) begin
      r_count <= r_count + {{(ADDR_W-1){1'b0}}, 1'b1};
    end
  end

  assign w_len_m1 = i_len - {{(ADDR_W-1){1'b0}}, 1'b1};
  assign o_addr   = i_base + r_count;
  assign o_last   = (r_count == w_len_m1);

endmodule

// File: rtl/dm_io_sequencer.sv
// DM I/O sequencer: loads host words into data memory, hands the memory to the
// cores, then streams a region back out. Optional load checksum: DM_IO_SEQUENCER_CHECKSUM_EN.
//
// state     | meaning
// ----------+-----------------------------------------------
// S_IDLE    | waiting for start, cores own DM
// S_LOAD    | writing host words into DM
// S_RUN     | cores own DM, waiting for core_done
// S_RD_ADDR | readback address presented to DM
// S_RD_WAIT | readback word offered on out_data
// S_FIN     | one-cycle done pulse
module dm_io_sequencer
  import dm_io_sequencer_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] load_base,
  input  logic [ADDR_W-1:0] load_len,
  input  logic [ADDR_W-1:0] store_base,
  input  logic [ADDR_W-1:0] store_len,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              core_done,
  input  logic [DATA_W-1:0] com_data_out,
  output logic [1:0]        status,
  output logic [ADDR_W-1:0] com_addr,
  output logic [DATA_W-1:0] com_data_in,
  output logic              com_wr_en,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              done
`ifdef DM_IO_SEQUENCER_CHECKSUM_EN
  ,
  output logic [DATA_W-1:0] load_sum
`endif
);

  seq_state_t r_state;
  seq_state_t w_next_state;

  logic [ADDR_W-1:0] r_load_base;
  logic [ADDR_W-1:0] r_load_len;
  logic [ADDR_W-1:0] r_store_base;
  logic [ADDR_W-1:0] r_store_len;
  logic [DATA_W-1:0] r_out_data;
  logic              r_first_rd;

  logic              w_start_acc;
  logic              w_wr;
  logic              w_cnt_clear;
  logic              w_cnt_inc;
  logic [ADDR_W-1:0] w_cnt_base;
  logic [ADDR_W-1:0] w_cnt_len;
  logic [ADDR_W-1:0] w_cnt_addr;
  logic              w_cnt_last;

  // Write strobe is gated by rst so a reset edge never commits a stray word
  assign w_wr = (r_state == S_LOAD) && in_valid && !rst;

  assign w_cnt_base = (r_state == S_LOAD) ? r_load_base : r_store_base;
  assign w_cnt_len  = (r_state == S_LOAD) ? r_load_len  : r_store_len;

  dm_addr_counter #(
    .ADDR_W (ADDR_W)
  ) u_addr_cnt (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_cnt_clear),
    .i_inc   (w_cnt_inc),
    .i_base  (w_cnt_base),
    .i_len   (w_cnt_len),
    .o_addr  (w_cnt_addr),
    .o_last  (w_cnt_last)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_load_base  <= '0;
      r_load_len   <= '0;
      r_store_base <= '0;
      r_store_len  <= '0;
      r_out_data   <= '0;
      r_first_rd   <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_first_rd <= (r_state == S_RD_ADDR);
      if (w_start_acc) begin
        r_load_base  <= load_base;
        r_load_len   <= load_len;
        r_store_base <= store_base;
        r_store_len  <= store_len;
      end
      if (r_first_rd) begin
        r_out_data <= com_data_out;
      end
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_start_acc  = 1'b0;
    w_cnt_clear  = 1'b0;
    w_cnt_inc    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_start_acc  = 1'b1;
          w_cnt_clear  = 1'b1;
          w_next_state = (load_len != '0) ? S_LOAD : S_RUN;
        end
      end
      S_LOAD: begin
        if (w_wr) begin
          if (w_cnt_last) begin
            w_cnt_clear  = 1'b1;
            w_next_state = S_RUN;
          end else begin
            w_cnt_inc = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (core_done) begin
          w_next_state = (r_store_len != '0) ? S_RD_ADDR : S_FIN;
        end
      end
      S_RD_ADDR: begin
        w_next_state = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        if (out_ready) begin
          if (w_cnt_last) begin
            w_cnt_clear  = 1'b1;
            w_next_state = S_FIN;
          end else begin
            w_cnt_inc    = 1'b1;
            w_next_state = S_RD_ADDR;
          end
        end
      end
      S_FIN: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Read address stays on the bus through RD_WAIT so the DM output holds too
  always_comb begin
    status      = ST_CORE;
    in_ready    = 1'b0;
    com_addr    = '0;
    com_data_in = '0;
    com_wr_en   = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      S_LOAD: begin
        status    = ST_LOAD;
        in_ready  = 1'b1;
        com_wr_en = w_wr;
        if (w_wr) begin
          com_addr    = w_cnt_addr;
          com_data_in = in_data;
        end
      end
      S_RD_ADDR: begin
        status   = ST_READ;
        com_addr = w_cnt_addr;
      end
      S_RD_WAIT: begin
        status    = ST_READ;
        com_addr  = w_cnt_addr;
        out_valid = 1'b1;
      end
      default: begin
        status = ST_CORE;
      end
    endcase
  end

  // First RD_WAIT cycle forwards the DM word directly, keeping 2 cycles/word
  assign out_data = r_first_rd ? com_data_out : r_out_data;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_FIN);

`ifdef DM_IO_SEQUENCER_CHECKSUM_EN
  logic [DATA_W-1:0] r_load_sum;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_load_sum <= '0;
    end else if (w_start_acc) begin
      r_load_sum <= '0;
    end else if (w_wr) begin
      r_load_sum <= r_load_sum + in_data;
    end
  end

  assign load_sum = r_load_sum;
`endif

endmodule

// File: doc/dm_io_sequencer.md
DM_IO_SEQUENCER -- requirements
Module: dm_io_sequencer

Interface
REQ-001 SHALL have parameters, one per line:
- DATA_W, 16, data word width.
- ADDR_W, 16, data-memory address width.
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse that begins a job.
- load_base  in  ADDR_W  first DM address to fill.
- load_len  in  ADDR_W  words to load.
- store_base  in  ADDR_W  first DM address to read back.
- store_len  in  ADDR_W  words to read back.
- in_data  in  DATA_W  host load word.
- in_valid  in  1  host word valid.
- in_ready  out  1  sequencer accepts in_data.
- core_done  in  1  level; cores finished computing.
- com_data_out  in  DATA_W  read data returned by the downstream selector.
- status  out  2  selector mode: 00 load, 01 cores own DM, 10 readback.
- com_addr  out  ADDR_W  DM address.
- com_data_in  out  DATA_W  DM write data.
- com_wr_en  out  1  DM write enable.
- out_data  out  DATA_W  readback word.
- out_valid  out  1  readback word valid.
- out_ready  in  1  consumer accepts out_data.
- busy  out  1  job in progress.
- done  out  1  one-cycle pulse at job end.

Function
REQ-003 SHALL implement the FSM states IDLE, LOAD, RUN, RD_ADDR, RD_WAIT and FIN.
REQ-004 IDLE: status=01, in_ready=0, com_wr_en=0. On start, latch all four base/len inputs. Go to LOAD if load_len!=0, otherwise to RUN.
REQ-005 LOAD: status=00 and in_ready=1. In a cycle with in_valid&in_ready: com_wr_en=1, com_addr=load_base+count, com_data_in=in_data, and count increments. After word load_len-1 is written, go to RUN and clear count.
REQ-006 In every cycle where in_valid=0 or the state is not LOAD, com_wr_en SHALL be 0. The write path is combinational from in_data/in_valid, with zero added latency.
REQ-007 RUN: status=01, com_wr_en=0. Wait for core_done=1. Then go to RD_ADDR if store_len!=0, otherwise to FIN.
REQ-008 RD_ADDR: status=10, com_addr=store_base+count, com_wr_en=0. Go to RD_WAIT next cycle. DM read latency is one cycle.
REQ-009 RD_WAIT, first cycle: register com_data_out into out_data and set out_valid=1. Hold out_data stable while out_valid=1 and out_ready=0.
REQ-010 RD_WAIT, on out_valid&out_ready: clear out_valid and increment count. Go to RD_ADDR, or to FIN after word store_len-1.
REQ-011 Maximum readback rate SHALL be one word per 2 cycles. Maximum load rate SHALL be one word per cycle.
REQ-012 FIN: done=1 for exactly one cycle, then IDLE.
REQ-013 busy=1 in every state except IDLE.
REQ-014 start SHALL be ignored while busy=1.
REQ-015 Address arithmetic SHALL be modulo 2^ADDR_W. base+count wraps past 0xFFFF to 0x0000.
REQ-016 count SHALL be ADDR_W bits wide. A length of 0 skips its phase.

Reset
REQ-017 rst=1 at a clock edge SHALL force, from any state:
- state=IDLE, count=0, out_valid=0, out_data=0, done=0, busy=0.
- com_wr_en=0, com_addr=0, com_data_in=0, status=01.
REQ-018 Reset mid-job SHALL abandon the job with no further DM write. The next start begins a fresh job.

Configuration
REQ-019 Macro DM_IO_SEQUENCER_CHECKSUM_EN present: add output load_sum [DATA_W]. It is the modulo-2^DATA_W sum of every word written in LOAD, cleared on accepted start and on rst, and stable from RUN until the next start.
REQ-020 Macro absent: port load_sum and its logic do not exist. All other behaviour is identical.

Structure
REQ-021 Shared package SHALL hold:
- status encodings ST_LOAD=2'b00, ST_CORE=2'b01, ST_READ=2'b10, shared with the selector.
- the FSM state enumeration.
- DATA_W/ADDR_W defaults.
REQ-022 Sub-module dm_addr_counter SHALL provide base+count generation with clear, increment and last-word flag. The FSM stays in the top module.

Verification
REQ-023 Load, no stall: start with load_base=0x0010, load_len=3, in_valid held 1 with words A,B,C -> com_wr_en high 3 consecutive cycles, addresses 0x10,0x11,0x12, status=00, then status=01.
REQ-024 Wrap: load_base=0xFFFE, load_len=4 -> writes to 0xFFFE, 0xFFFF, 0x0000, 0x0001.
REQ-025 Readback with backpressure: store_base=0x0020, store_len=2, DM holds 0x1234, 0x5678, out_ready low 3 cycles on the first word -> out_data stays 0x1234 throughout the stall, then 0x5678 is delivered, then done pulses once.
REQ-026 Zero lengths: load_len=0, store_len=0, core_done=1 -> IDLE->RUN->FIN, done pulses, com_wr_en never 1, status never 10.
REQ-027 Reset mid-LOAD after 2 of 5 words -> next cycle: IDLE, status=01, com_wr_en=0, busy=0. A new start reloads from load_base.
REQ-028 With DM_IO_SEQUENCER_CHECKSUM_EN: load words 0xFFFF, 0x0002 -> load_sum=0x0001 in RUN.
